// File: rtl/imm_decode_stage_if.sv
// ============================================================================
// Module   : imm_decode_stage_if
// Brief    : Fetch-side and register-read-side handshakes of imm_decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, out_instr, imm, fmt, illegal, illegal_count
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, out_instr, imm, fmt, illegal, illegal_count
    );
endinterface

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module   : imm_decode_stage
// Brief    : Registered RV32/RV64 immediate decoder behind a 2-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    imm_decode_stage_if.slave  bus
);
    localparam logic [2:0]       c_FMT_R   = 3'd0;
    localparam logic [2:0]       c_FMT_I   = 3'd1;
    localparam logic [2:0]       c_FMT_S   = 3'd2;
    localparam logic [2:0]       c_FMT_B   = 3'd3;
    localparam logic [2:0]       c_FMT_U   = 3'd4;
    localparam logic [2:0]       c_FMT_J   = 3'd5;
    localparam logic [2:0]       c_FMT_Z   = 3'd6;
    localparam logic [2:0]       c_FMT_ILL = 3'd7;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]      w_op;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_push;
    logic            w_pop;

    logic [1:0]       r_count;
    logic             r_live;
    logic [31:0]      r_instr [2];
    logic [XLEN-1:0]  r_imm   [2];
    logic [2:0]       r_fmt   [2];
    logic [CNT_W-1:0] r_ill_cnt;

    assign w_op = bus.instr[6:0];

    always_comb begin
        w_fmt = c_FMT_ILL;
        w_imm = '0;
        case (w_op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_fmt = c_FMT_I;
                w_imm = XLEN'($signed(bus.instr[31:20]));
            end
            7'b1110011: begin
                if (bus.instr[14]) begin
                    w_fmt = c_FMT_Z;
                    w_imm = XLEN'(bus.instr[19:15]);
                end else begin
                    w_fmt = c_FMT_I;
                    w_imm = XLEN'($signed(bus.instr[31:20]));
                end
            end
            7'b0100011: begin
                w_fmt = c_FMT_S;
                w_imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            end
            7'b1100011: begin
                w_fmt = c_FMT_B;
                w_imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                       bus.instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = c_FMT_U;
                w_imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_fmt = c_FMT_J;
                w_imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                       bus.instr[30:21], 1'b0}));
            end
            7'b0110011: begin
                w_fmt = c_FMT_R;
            end
            default: begin
                w_fmt = c_FMT_ILL;
            end
        endcase
    end

    // r_live holds in_ready low for one cycle after reset releases
    assign bus.in_ready      = r_live & ~rst & (r_count != 2'd2);
    assign bus.out_valid     = (r_count != 2'd0);
    assign bus.out_instr     = r_instr[0];
    assign bus.imm           = r_imm[0];
    assign bus.fmt           = r_fmt[0];
    assign bus.illegal       = (r_fmt[0] == c_FMT_ILL);
    assign bus.illegal_count = r_ill_cnt;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // Entry 0 is always the head, so outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_live     <= 1'b0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
            r_imm[0]   <= '0;
            r_imm[1]   <= '0;
            r_fmt[0]   <= c_FMT_R;
            r_fmt[1]   <= c_FMT_R;
            r_ill_cnt  <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_instr[0] <= bus.instr;
                        r_imm[0]   <= w_imm;
                        r_fmt[0]   <= w_fmt;
                        r_count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_instr[0] <= bus.instr;
                        r_imm[0]   <= w_imm;
                        r_fmt[0]   <= w_fmt;
                    end else if (w_push) begin
                        r_instr[1] <= bus.instr;
                        r_imm[1]   <= w_imm;
                        r_fmt[1]   <= w_fmt;
                        r_count    <= 2'd2;
                    end else if (w_pop) begin
                        r_count    <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_instr[0] <= r_instr[1];
                        r_imm[0]   <= r_imm[1];
                        r_fmt[0]   <= r_fmt[1];
                        r_count    <= 2'd1;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
            if (w_pop && (r_fmt[0] == c_FMT_ILL) && (r_ill_cnt != c_CNT_MAX)) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// Module   : tb_imm_decode_stage
// Brief    : Self-checking bench; XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8 instances
//            share one stimulus stream and one reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32), .CNT_W(2)) b32 ();
    imm_decode_stage_if #(.XLEN(64), .CNT_W(8)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.instr     = instr;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.instr     = instr;
    assign b64.out_ready = out_ready;

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_decode_stage #(.XLEN(64), .CNT_W(8)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: assemble the unsigned field value, then subtract 2^n
    // when its top bit is set to obtain the two's-complement value.
    function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm,
                                       output logic [2:0] fmt);
        logic [63:0] raw;
        int          nb;
        raw = 64'd0;
        nb  = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin fmt = 3'd1; raw = 64'(w[31:20]); nb = 12; end
            7'h73: begin
                if (w[14]) begin fmt = 3'd6; raw = 64'(w[19:15]); nb = 0; end
                else       begin fmt = 3'd1; raw = 64'(w[31:20]); nb = 12; end
            end
            7'h23: begin fmt = 3'd2; raw = (64'(w[31:25]) << 5) + 64'(w[11:7]); nb = 12; end
            7'h63: begin
                fmt = 3'd3; nb = 13;
                raw = (64'(w[31]) << 12) + (64'(w[7]) << 11) + (64'(w[30:25]) << 5) + (64'(w[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; raw = 64'(w[31:12]) << 12; nb = 32; end
            7'h6F: begin
                fmt = 3'd5; nb = 21;
                raw = (64'(w[31]) << 20) + (64'(w[19:12]) << 12) + (64'(w[20]) << 11) + (64'(w[30:21]) << 1);
            end
            7'h33:   begin fmt = 3'd0; end
            default: begin fmt = 3'd7; end
        endcase
        if (nb > 0 && raw[nb-1]) raw = raw - (64'd1 << nb);
        imm = raw;
    endfunction

    logic [31:0] q[$];
    int          m_ic32, m_ic64;
    bit          m_recover = 1'b1;
    bit          chk_on    = 1'b0;

    always @(posedge clk) begin
        logic [63:0] ei;
        logic [2:0]  ef;
        bit          push, pop;
        if (rst) begin
            q.delete();
            m_ic32    = 0;
            m_ic64    = 0;
            m_recover = 1'b1;
            chk_on    = 1'b1;
        end else begin
            push = in_valid && !m_recover && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (pop) begin
                ref_decode(q[0], ei, ef);
                if (ef == 3'd7) begin
                    if (m_ic32 < 3)   m_ic32++;
                    if (m_ic64 < 255) m_ic64++;
                end
                void'(q.pop_front());
            end
            if (push) q.push_back(instr);
            m_recover = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [63:0] ei;
        logic [2:0]  ef;
        bit          exp_rdy;
        if (chk_on) begin
            exp_rdy = !rst && !m_recover && (q.size() < 2);
            chk("in_ready32", 64'(b32.in_ready), 64'(exp_rdy));
            chk("in_ready64", 64'(b64.in_ready), 64'(exp_rdy));
            chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
            chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
            chk("ill_cnt32", 64'(b32.illegal_count), 64'(m_ic32));
            chk("ill_cnt64", 64'(b64.illegal_count), 64'(m_ic64));
            if (q.size() > 0) begin
                ref_decode(q[0], ei, ef);
                chk("out_instr32", 64'(b32.out_instr), 64'(q[0]));
                chk("out_instr64", 64'(b64.out_instr), 64'(q[0]));
                chk("imm32", 64'(b32.imm), 64'(ei[31:0]));
                chk("imm64", b64.imm, ei);
                chk("fmt32", 64'(b32.fmt), 64'(ef));
                chk("fmt64", 64'(b64.fmt), 64'(ef));
                chk("illegal32", 64'(b32.illegal), 64'(ef == 3'd7));
                chk("illegal64", 64'(b64.illegal), 64'(ef == 3'd7));
            end
        end
    end

    task automatic send_chk(input string name, input logic [31:0] w,
                            input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
        logic [63:0] e32;
        e32 = 64'(exp_imm[31:0]);
        in_valid = 1'b1;
        instr    = w;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(b64.in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_vld"}, 64'(b64.out_valid), 64'd1);
        chk({name, "_imm32"}, 64'(b32.imm), e32);
        chk({name, "_imm64"}, b64.imm, exp_imm);
        chk({name, "_fmt"}, 64'(b64.fmt), 64'(exp_fmt));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_vld"},   64'(b32.out_valid), 64'd0);
        chk({name, "_imm"},   b64.imm, 64'd0);
        chk({name, "_fmt"},   64'(b64.fmt), 64'd0);
        chk({name, "_ill"},   64'(b64.illegal), 64'd0);
        chk({name, "_instr"}, 64'(b64.out_instr), 64'd0);
        chk({name, "_cnt"},   64'(b32.illegal_count), 64'd0);
        chk({name, "_rdy"},   64'(b32.in_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};
        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        send_chk("i_pos",  32'h7FF00013, 64'h0000_0000_0000_07FF, 3'd1);
        send_chk("i_neg",  32'hFFF00013, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        send_chk("b_neg",  32'h80000063, 64'hFFFF_FFFF_FFFF_F000, 3'd3);
        send_chk("j_b20",  32'h0010006F, 64'h0000_0000_0000_0800, 3'd5);
        send_chk("z_31",   32'h000FD073, 64'h0000_0000_0000_001F, 3'd6);
        send_chk("u_neg",  32'hABCDE037, 64'hFFFF_FFFF_ABCD_E000, 3'd4);
        send_chk("s_m1",   32'hFE000FA3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2);
        send_chk("s_m33",  32'hFC000FA3, 64'hFFFF_FFFF_FFFF_FFDF, 3'd2);
        send_chk("r_zero", 32'h00B50533, 64'h0, 3'd0);

        // Illegal-opcode counter saturation on the CNT_W=2 instance
        do_reset();
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            send_chk("ill", 32'h0000007F, 64'h0, 3'd7);
            chk("ill_sat32", 64'(b32.illegal_count), 64'((k < 3) ? k : 3));
            chk("ill_cnt64", 64'(b64.illegal_count), 64'(k));
        end

        // Backpressure: only two of three words fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        @(posedge clk); #1;
        instr     = 32'h00200113;
        @(posedge clk); #1;
        instr     = 32'h00300193;
        @(negedge clk);
        chk("bp_full_rdy", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_instr", 64'(b32.out_instr), 64'h00100093);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_a", 64'(b32.out_instr), 64'h00100093);
        chk("bp_rdy_a", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_head_b", 64'(b32.out_instr), 64'h00200113);
        chk("bp_rdy_b", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_head_c", 64'(b32.out_instr), 64'h00300193);
        chk("bp_vld_c", 64'(b32.out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset while two entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h0000007F;
        @(posedge clk); #1;
        instr     = 32'h00500293;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        do_reset();
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        chk("midrst_rdy_up", 64'(b32.in_ready), 64'd1);
        chk("midrst_empty", 64'(b32.out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            r         = $urandom();
            instr     = {r[31:7], ops[$urandom_range(0, 11)]};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
